// File: rtl/b_alu.sv
// Sequential sign-magnitude ALU core for the 8-bit calculator: chains operator
// keys left-to-right through an accumulator and registers result and error flag.
module b_alu (
  input  logic       i_sys_clock,
  input  logic       i_sys_reset,
  input  logic       i_b_alu_en,
  input  logic       i_b_alu_equal,
  input  logic [3:0] i_b_alu_op_keycode,
  input  logic [8:0] i_b_alu_operand,
  output logic [8:0] o_b_alu_result,
  output logic       o_b_alu_overflow_flag
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_NOT  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SLL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLA  = 4'd11
  } op_t;

  state_t     state;
  logic [3:0] pend_op;
  logic [8:0] acc;
  logic       prev_en;
  logic       prev_equal;

  logic       en_ev;
  logic       equal_ev;
  logic [8:0] operand_n;

  logic signed [19:0] a_int;
  logic signed [19:0] b_int;
  logic signed [19:0] wide;
  logic [8:0]         a_tc;
  logic [8:0]         b_tc;
  logic [8:0]         tc;
  logic [7:0]         amt;
  logic               b_neg;
  logic               use_tc;
  logic               f_err;
  logic [8:0]         f_val;

  function automatic logic signed [19:0] sm_to_int(input logic [8:0] sm);
    logic signed [19:0] mag;
    mag = signed'({12'd0, sm[7:0]});
    return sm[8] ? -mag : mag;
  endfunction

  // Sign is only set for a nonzero magnitude, so -0 is never produced.
  function automatic logic [8:0] int_to_sm(input logic signed [19:0] v);
    logic [19:0] mag;
    mag = (v < 0) ? 20'(-v) : 20'(v);
    return {(v < 0), mag[7:0]};
  endfunction

  assign en_ev     = i_b_alu_en & ~prev_en;
  assign equal_ev  = i_b_alu_equal & ~prev_equal;
  assign operand_n = (i_b_alu_operand[7:0] == '0) ? '0 : i_b_alu_operand;

  always_comb begin
    a_int  = sm_to_int(acc);
    b_int  = sm_to_int(i_b_alu_operand);
    a_tc   = a_int[8:0];
    b_tc   = b_int[8:0];
    amt    = i_b_alu_operand[7:0];
    b_neg  = i_b_alu_operand[8] && (amt != '0);
    wide   = '0;
    tc     = '0;
    use_tc = 1'b0;
    f_err  = 1'b0;
    case (pend_op)
      OP_ADD: wide = a_int + b_int;
      OP_SUB: wide = a_int - b_int;
      OP_MUL: wide = a_int * b_int;
      OP_DIV: begin
        if (b_int == 0) f_err = 1'b1;
        else            wide  = a_int / b_int;
      end
      OP_NOT: begin tc = ~a_tc;        use_tc = 1'b1; end
      OP_AND: begin tc = a_tc & b_tc;  use_tc = 1'b1; end
      OP_OR:  begin tc = a_tc | b_tc;  use_tc = 1'b1; end
      OP_XOR: begin tc = a_tc ^ b_tc;  use_tc = 1'b1; end
      OP_SRL: begin
        f_err  = b_neg;
        use_tc = 1'b1;
        tc     = (amt >= 8'd9) ? '0 : (a_tc >> amt);
      end
      OP_SLL: begin
        f_err  = b_neg;
        use_tc = 1'b1;
        tc     = (amt >= 8'd9) ? '0 : (a_tc << amt);
      end
      OP_SRA: begin
        f_err  = b_neg;
        use_tc = 1'b1;
        tc     = (amt >= 8'd9) ? {9{a_tc[8]}} : 9'($signed(a_tc) >>> amt);
      end
      OP_SLA: begin
        // Any nonzero value shifted by 8 or more exceeds the 8-bit magnitude.
        if (b_neg)                          f_err = 1'b1;
        else if (a_int == 0)                wide  = '0;
        else if (amt >= 8'd8)               f_err = 1'b1;
        else                                wide  = a_int <<< amt[2:0];
      end
      default: f_err = 1'b1;
    endcase
    if (use_tc) wide = {{11{tc[8]}}, tc};
    if (wide > 20'sd255 || wide < -20'sd255) f_err = 1'b1;
    f_val = int_to_sm(wide);
  end

  always_ff @(posedge i_sys_clock) begin
    prev_en    <= i_b_alu_en;
    prev_equal <= i_b_alu_equal;
    if (i_sys_reset) begin
      state                 <= ST_EMPTY;
      pend_op               <= '0;
      acc                   <= '0;
      o_b_alu_result        <= '0;
      o_b_alu_overflow_flag <= 1'b0;
    end else if (state != ST_ERROR) begin
      if (equal_ev) begin
        case (state)
          ST_EMPTY: begin
            o_b_alu_result <= operand_n;
            state          <= ST_DONE;
          end
          ST_PENDING: begin
            pend_op <= '0;
            if (f_err) begin
              o_b_alu_result        <= '0;
              o_b_alu_overflow_flag <= 1'b1;
              state                 <= ST_ERROR;
            end else begin
              o_b_alu_result <= f_val;
              acc            <= f_val;
              state          <= ST_DONE;
            end
          end
          default: ;
        endcase
      end else if (en_ev) begin
        if (state == ST_PENDING) begin
          if (f_err) begin
            o_b_alu_result        <= '0;
            o_b_alu_overflow_flag <= 1'b1;
            state                 <= ST_ERROR;
          end else begin
            acc            <= f_val;
            pend_op        <= i_b_alu_op_keycode;
            o_b_alu_result <= f_val;
          end
        end else begin
          acc            <= operand_n;
          pend_op        <= i_b_alu_op_keycode;
          o_b_alu_result <= operand_n;
          state          <= ST_PENDING;
        end
      end
    end
  end

endmodule

// File: tb/tb_b_alu.sv
// Directed self-checking bench for b_alu: binary ops, unary/bitwise/shift ops,
// chaining, event priority, negative zero and sticky error handling.
module tb_b_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       equal = 1'b0;
  logic [3:0] key = '0;
  logic [8:0] operand = '0;
  logic [8:0] result;
  logic       flag;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  b_alu dut (
    .i_sys_clock          (clk),
    .i_sys_reset          (rst),
    .i_b_alu_en           (en),
    .i_b_alu_equal        (equal),
    .i_b_alu_op_keycode   (key),
    .i_b_alu_operand      (operand),
    .o_b_alu_result       (result),
    .o_b_alu_overflow_flag(flag)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic press_en(input logic [8:0] v, input logic [3:0] k);
    @(negedge clk) begin operand = v; key = k; en = 1'b1; end
    @(negedge clk) en = 1'b0;
  endtask

  task automatic press_eq(input logic [8:0] v);
    @(negedge clk) begin operand = v; equal = 1'b1; end
    @(negedge clk) equal = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (result !== 9'h000 || flag !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h flag=%b, want result=000 flag=0", result, flag);
    end
    press_eq(9'h002);
    vectors++;
    if (result !== 9'h002 || flag !== 1'b0) begin
      errors++;
      $display("FAIL equal_no_op: result=%h flag=%b, want 002 flag=0", result, flag);
    end
  endtask

  task automatic test_arith();
    logic [3:0] ks [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [8:0] ex [4] = '{9'h006, 9'h102, 9'h008, 9'h000};
    for (int i = 0; i < 4; i++) begin
      press_en(9'h002, ks[i]);
      press_eq(9'h004);
      vectors++;
      if (result !== ex[i] || flag !== 1'b0) begin
        errors++;
        $display("FAIL arith_op%0d: result=%h flag=%b, want %h flag=0", ks[i], result, flag, ex[i]);
      end
    end
  endtask

  task automatic test_not();
    logic [8:0] in [2] = '{9'h002, 9'h102};
    logic [8:0] ex [2] = '{9'h103, 9'h001};
    for (int i = 0; i < 2; i++) begin
      press_en(in[i], 4'd4);
      press_eq(9'h0AA);
      vectors++;
      if (result !== ex[i] || flag !== 1'b0) begin
        errors++;
        $display("FAIL not_%h: result=%h flag=%b, want %h flag=0", in[i], result, flag, ex[i]);
      end
    end
  endtask

  task automatic test_bitwise();
    logic [3:0] ks [3] = '{4'd5, 4'd6, 4'd7};
    logic [8:0] bs [3] = '{9'h002, 9'h003, 9'h003};
    logic [8:0] ex [3] = '{9'h002, 9'h0F7, 9'h0F5};
    for (int i = 0; i < 3; i++) begin
      press_en(9'h0F6, ks[i]);
      press_eq(bs[i]);
      vectors++;
      if (result !== ex[i] || flag !== 1'b0) begin
        errors++;
        $display("FAIL bitwise_op%0d: result=%h flag=%b, want %h", ks[i], result, flag, ex[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0] ks [4] = '{4'd8, 4'd9, 4'd11, 4'd10};
    logic [8:0] in [4] = '{9'h020, 9'h002, 9'h002, 9'h102};
    logic [8:0] ex [4] = '{9'h002, 9'h020, 9'h020, 9'h101};
    for (int i = 0; i < 4; i++) begin
      press_en(in[i], ks[i]);
      press_eq(9'h004);
      vectors++;
      if (result !== ex[i] || flag !== 1'b0) begin
        errors++;
        $display("FAIL shift_op%0d: result=%h flag=%b, want %h", ks[i], result, flag, ex[i]);
      end
    end
  endtask

  task automatic test_chain();
    press_en(9'd10, 4'd0);
    vectors++;
    if (result !== 9'd10) begin
      errors++;
      $display("FAIL chain_load: result=%h, want %h", result, 9'd10);
    end
    press_en(9'd8, 4'd2);
    vectors++;
    if (result !== 9'd18) begin
      errors++;
      $display("FAIL chain_mid: result=%h, want %h", result, 9'd18);
    end
    press_eq(9'd2);
    vectors++;
    if (result !== 9'd36 || flag !== 1'b0) begin
      errors++;
      $display("FAIL chain_eq: result=%h flag=%b, want %h", result, flag, 9'd36);
    end
    press_eq(9'd5);
    vectors++;
    if (result !== 9'd36) begin
      errors++;
      $display("FAIL chain_eq_again: result=%h, want %h", result, 9'd36);
    end
  endtask

  task automatic test_priority_negzero();
    do_reset();
    // Both strobes together: equal must win, leaving DONE with no pending add.
    @(negedge clk) begin operand = 9'd7; key = 4'd0; en = 1'b1; equal = 1'b1; end
    @(negedge clk) begin en = 1'b0; equal = 1'b0; end
    press_eq(9'd9);
    vectors++;
    if (result !== 9'd7) begin
      errors++;
      $display("FAIL en_equal_same_cycle: result=%h, want %h", result, 9'd7);
    end
    do_reset();
    press_eq(9'h100);
    vectors++;
    if (result !== 9'h000) begin
      errors++;
      $display("FAIL neg_zero: result=%h, want 000", result);
    end
  endtask

  task automatic test_errors();
    logic [8:0] a  [4] = '{9'd255, 9'd2, 9'd2, 9'd2};
    logic [3:0] ks [4] = '{4'd0, 4'd3, 4'd11, 4'd12};
    logic [8:0] b  [4] = '{9'd255, 9'd0, 9'h101, 9'd1};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      press_en(a[i], ks[i]);
      press_eq(b[i]);
      vectors++;
      if (result !== 9'h000 || flag !== 1'b1) begin
        errors++;
        $display("FAIL error_op%0d: result=%h flag=%b, want 000 flag=1", ks[i], result, flag);
      end
    end
    press_en(9'd3, 4'd0);
    press_eq(9'd4);
    vectors++;
    if (result !== 9'h000 || flag !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: result=%h flag=%b, want 000 flag=1", result, flag);
    end
    do_reset();
    vectors++;
    if (result !== 9'h000 || flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_flag: result=%h flag=%b, want 000 flag=0", result, flag);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_not();
    test_bitwise();
    test_shift();
    test_chain();
    test_priority_negzero();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/b_alu.md
Name: b_alu

Overview:
- Sequential integer ALU core of the 8-bit calculator.
- Accepts 9-bit sign-magnitude operands and a 4-bit operator keycode from the keypad/decoder front end.
- Chains operations left-to-right through an internal accumulator and presents the registered result plus an error/overflow flag to the display logic.

Parameters:
None. Width is fixed: 9-bit sign-magnitude, bit 8 = sign, bits 7:0 = magnitude, legal range -255..+255.

Ports:
i_sys_clock  input  1  system clock; all state updates on rising edge
i_sys_reset  input  1  synchronous, active-high reset
i_b_alu_en  input  1  operator key strobe; rising edge commits operand + keycode
i_b_alu_equal  input  1  equal key; rising edge evaluates pending operation
i_b_alu_op_keycode  input  4  operator: 0 add, 1 sub, 2 mul, 3 div, 4 NOT, 5 AND, 6 OR, 7 XOR, 8 >>, 9 <<, 10 >>>, 11 <<<, 12-15 invalid
i_b_alu_operand  input  9  current operand, sign-magnitude
o_b_alu_result  output  9  registered result, sign-magnitude
o_b_alu_overflow_flag  output  1  registered overflow/invalid flag

Behaviour:
- Reset (synchronous, highest priority):
  - acc=0, pending op=NONE, state=EMPTY, o_b_alu_result=0, o_b_alu_overflow_flag=0.
- Edge detection:
  - prev_en/prev_equal registers sample the inputs every cycle, including during reset.
  - An event is input=1 while prev=0. Held levels trigger once.
- States: EMPTY (no pending op), PENDING (acc + op held), DONE (result shown), ERROR.
- en event:
  - EMPTY or DONE: acc <= operand, pending <= keycode, go to PENDING, result <= operand.
  - PENDING: acc <= f(acc, operand, pending), pending <= keycode, result <= new acc. Stay in PENDING unless an error occurs.
- equal event:
  - EMPTY: result <= operand, go to DONE.
  - PENDING: result <= f(acc, operand, pending), acc <= result, pending <= NONE, go to DONE.
  - DONE: no change, so repeated equal presses hold the result.
- en and equal events in the same cycle: equal wins and en is ignored.
- Latency: outputs update on the same clock edge that samples the event, so they are visible one cycle after the input rises.
- Operation f(a,b):
  - Add, sub, mul: signed; true result outside ±255 raises the error.
  - Div: signed, truncates toward zero, sign = sign_a XOR sign_b. b = 0 raises the error.
  - NOT: unary on a; b is ignored.
  - Bitwise ops (NOT, AND, OR, XOR): convert operands to 9-bit two's complement, operate on all 9 bits, convert back. A result of -256 raises the error.
- Shifts (amount = b magnitude):
  - b negative: error.
  - Amount ≥ 9: full shift-out.
  - >> : logical on the 9-bit two's-complement pattern (zero fill).
  - << : logical, truncated to 9 bits, no overflow check.
  - >>> : arithmetic (sign fill).
  - <<< : arithmetic; result outside ±255 or a sign change raises the error.
- Keycodes 12-15: error.
- Error handling:
  - o_b_alu_overflow_flag <= 1, o_b_alu_result <= 0, go to ERROR.
  - ERROR is sticky: all en/equal events are ignored until reset.
- Negative zero (sign=1, magnitude=0):
  - Treated as 0 on input.
  - Never produced on output (sign forced to 0).

Test Plan:
- Reset then operand 2, equal (no op) -> result 9'h002, flag 0.
- Basic arithmetic, each as 2, en with op, operand 4, equal:
  - add -> 6
  - sub -> 9'b1_0000_0010 (-2)
  - mul -> 8
  - div -> 0
- Unary NOT, each as operand, en op 4, equal:
  - 2 -> 9'b1_0000_0011 (-3)
  - -2 (9'b1_0000_0010) -> 1
- Bitwise, 0xF6 op 3 (AND uses 2):
  - AND with 2 -> 2
  - OR with 3 -> 0xF7
  - XOR with 3 -> 0xF5
- Shifts, each as operand, en op, amount 4, equal:
  - 0x20 >> 4 -> 2
  - 2 << 4 -> 32
  - 2 <<< 4 -> 32
  - -2 >>> 4 -> 9'b1_0000_0001 (-1)
- Chain and errors:
  - 10, en add; 8, en mul (result shows 18); 2, equal -> 36. Equal again -> 36 unchanged.
  - 255 + 255 -> flag 1, result 0.
  - 2 / 0 -> flag 1.
  - 2 <<< -1 -> flag 1.
  - Reset clears flag.
